sd_blk_arbiter: RTL

- Shares one MiSTer SD block-level channel (lba/rd/wr/ack plus byte-buffer read-back) among NUM_REQ floppy-drive requesters, each one a wd1793 instance inside the fdc.
- Round-robin arbitration; one grant is held for a full block transfer.
- Forwards the winner's LBA and buffer data to the SD side, and routes sd_ack only to the granted requester.
- Sits between the fdc's per-drive sd_* arrays and the single-channel hps_io SD port.

---
 rtl/fdc_pkg.sv | 20 ++
 rtl/sd_blk_arbiter_rr_pick.sv | 27 ++
 rtl/sd_blk_arbiter.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/fdc_pkg.sv
// Shared types and constants for the fdc SD-channel arbitration logic.
package fdc_pkg;

  localparam int SD_LBA_W = 32;
  localparam int TO_W     = 24;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT_ACK,
    XFER,
    RELEASE
  } arb_state_t;

  typedef enum logic {
    OP_RD,
    OP_WR
  } op_t;

endpackage

// File: rtl/sd_blk_arbiter_rr_pick.sv
// Combinational round-robin priority encoder: the first pending requester
// at or after rr_ptr (wrapping modulo N) wins.
module rr_pick #(
  parameter int N = 4
) (
  input  logic [N-1:0] pending,
  input  logic [1:0]   rr_ptr,
  output logic         found,
  output logic [1:0]   idx
);

  // Walk offsets from farthest to nearest so the nearest pending one is kept.
  always_comb begin
    logic [1:0] pos;
    found = 1'b0;
    idx   = rr_ptr;
    pos   = '0;
    for (int k = N - 1; k >= 0; k--) begin
      pos = 2'((int'(rr_ptr) + k) % N);
      if (pending[pos]) begin
        found = 1'b1;
        idx   = pos;
      end
    end
  end

endmodule

// File: rtl/sd_blk_arbiter.sv
// Shares the single hps_io SD block channel among the fdc's drive requesters.
// One grant covers a complete block transfer; arbitration is round-robin.
//
// state    | meaning
// ---------+-----------------------------------------------------------------
// IDLE     | no grant; pick the next pending requester and latch its LBA
// ISSUE    | raise sd_rd or sd_wr, clear the ack timeout counter
// WAIT_ACK | waiting for sd_ack; abort on request drop or timeout
// XFER     | transfer running, req_ack of the winner follows sd_ack
// RELEASE  | wait for the winner to drop its request, then advance rr_ptr
module sd_blk_arbiter
  import fdc_pkg::*;
#(
  parameter int          NUM_REQ     = 4,
  parameter logic [23:0] ACK_TIMEOUT = 24'd12_500_000
) (
  input  logic                         CLK,
  input  logic                         RESET_N,
  input  logic [NUM_REQ-1:0]           req_rd,
  input  logic [NUM_REQ-1:0]           req_wr,
  input  logic [SD_LBA_W*NUM_REQ-1:0]  req_lba,
  input  logic [8*NUM_REQ-1:0]         req_buff_din,
  output logic [NUM_REQ-1:0]           req_ack,
  output logic [SD_LBA_W-1:0]          sd_lba,
  output logic                         sd_rd,
  output logic                         sd_wr,
  input  logic                         sd_ack,
  output logic [7:0]                   sd_buff_din,
  output logic [1:0]                   grant_idx,
  output logic                         busy,
  output logic                         timeout_err
);

  localparam logic [TO_W-1:0] TO_LAST  = ACK_TIMEOUT - 24'd1;
  localparam logic [TO_W-1:0] TO_SAT   = '1;
  localparam logic [1:0]      LAST_IDX = 2'(NUM_REQ - 1);

  logic [SD_LBA_W-1:0] lba_arr [NUM_REQ];
  logic [7:0]          buf_arr [NUM_REQ];

  logic [NUM_REQ-1:0]  rd_s1, rd_s2, wr_s1, wr_s2;
  logic                ack_s1, ack_s2;
  logic [NUM_REQ-1:0]  pend;

  arb_state_t          state_q, state_d;
  op_t                 op_q, op_d;
  logic [1:0]          grant_q, grant_d;
  logic [1:0]          rr_q, rr_d;
  logic [SD_LBA_W-1:0] lba_q, lba_d;
  logic                sd_rd_q, sd_rd_d;
  logic                sd_wr_q, sd_wr_d;
  logic [TO_W-1:0]     cnt_q, cnt_d;
  logic                to_q, to_d;

  logic                pick_found;
  logic [1:0]          pick_idx;
  logic                grant_pend;

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
    assign lba_arr[i] = req_lba[i*SD_LBA_W +: SD_LBA_W];
    assign buf_arr[i] = req_buff_din[i*8 +: 8];
  end

  // Two-flop synchronizers for the handshake levels; the FSM uses only *_s2.
  always_ff @(negedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      rd_s1  <= '0;
      rd_s2  <= '0;
      wr_s1  <= '0;
      wr_s2  <= '0;
      ack_s1 <= 1'b0;
      ack_s2 <= 1'b0;
    end else begin
      rd_s1  <= req_rd;
      rd_s2  <= rd_s1;
      wr_s1  <= req_wr;
      wr_s2  <= wr_s1;
      ack_s1 <= sd_ack;
      ack_s2 <= ack_s1;
    end
  end

  assign pend       = rd_s2 | wr_s2;
  assign grant_pend = pend[grant_q];

  rr_pick #(
    .N       (NUM_REQ)
  ) u_rr_pick (
    .pending (pend),
    .rr_ptr  (rr_q),
    .found   (pick_found),
    .idx     (pick_idx)
  );

  // State register plus the registered channel outputs.
  always_ff @(negedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q <= IDLE;
      op_q    <= OP_RD;
      grant_q <= '0;
      rr_q    <= '0;
      lba_q   <= '0;
      sd_rd_q <= 1'b0;
      sd_wr_q <= 1'b0;
      cnt_q   <= '0;
      to_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      grant_q <= grant_d;
      rr_q    <= rr_d;
      lba_q   <= lba_d;
      sd_rd_q <= sd_rd_d;
      sd_wr_q <= sd_wr_d;
      cnt_q   <= cnt_d;
      to_q    <= to_d;
    end
  end

  // Next-state logic; the LBA stays frozen from grant until the next IDLE pick.
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    grant_d = grant_q;
    rr_d    = rr_q;
    lba_d   = lba_q;
    sd_rd_d = sd_rd_q;
    sd_wr_d = sd_wr_q;
    cnt_d   = cnt_q;
    to_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (pick_found) begin
          grant_d = pick_idx;
          op_d    = wr_s2[pick_idx] ? OP_WR : OP_RD;
          lba_d   = lba_arr[pick_idx];
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        sd_rd_d = (op_q == OP_RD);
        sd_wr_d = (op_q == OP_WR);
        cnt_d   = '0;
        state_d = WAIT_ACK;
      end
      WAIT_ACK: begin
        if (ack_s2) begin
          sd_rd_d = 1'b0;
          sd_wr_d = 1'b0;
          state_d = XFER;
        end else if (!grant_pend) begin
          sd_rd_d = 1'b0;
          sd_wr_d = 1'b0;
          state_d = RELEASE;
        end else if ((ACK_TIMEOUT != 24'd0) && (cnt_q == TO_LAST)) begin
          to_d    = 1'b1;
          sd_rd_d = 1'b0;
          sd_wr_d = 1'b0;
          state_d = RELEASE;
        end else if (cnt_q != TO_SAT) begin
          cnt_d = cnt_q + 24'd1;
        end
      end
      XFER: begin
        sd_rd_d = 1'b0;
        sd_wr_d = 1'b0;
        if (!ack_s2) begin
          state_d = RELEASE;
        end
      end
      RELEASE: begin
        if (!grant_pend) begin
          rr_d    = (grant_q == LAST_IDX) ? 2'd0 : grant_q + 2'd1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Only the granted requester sees the ack, and only while a transfer is live.
  always_comb begin
    req_ack = '0;
    if (ack_s2 && ((state_q == WAIT_ACK) || (state_q == XFER))) begin
      req_ack[grant_q] = 1'b1;
    end
  end

  assign sd_lba      = lba_q;
  assign sd_rd       = sd_rd_q;
  assign sd_wr       = sd_wr_q;
  assign grant_idx   = grant_q;
  assign busy        = (state_q != IDLE);
  assign timeout_err = to_q;
  assign sd_buff_din = buf_arr[grant_q];

endmodule
